tb_mem_model: RTL and testbench
===============================

# tb_mem_model

Parametrised simulation memory for the core testbenches. It replaces the fixed single-cycle `mem` model and attaches directly to the picorv32 native memory bus (`mem_valid`/`mem_ready`). It adds configurable depth, configurable response latency with optional pseudo-random stalls, a pass/fail MMIO register, protocol and out-of-range error flags, and a transaction counter. The array is named `sram` so the bench can preload it with `$readmemh`.

## Interface

Parameters:

- `DEPTH_WORDS`, 32768: number of 32-bit words; must be a power of two.
- `LATENCY`, 1: cycles from the accept cycle to `mem_ready`; must be ≥ 1.
- `STALL_EN`, 0: when 1, adds 0–3 pseudo-random wait cycles per transaction.
- `PASS_ADDR`, 32'h1000_0000: word address of the MMIO test-status register.
- `PASS_VALUE`, 32'd123456789: write value that signals pass.

Ports:

- `clock` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: request valid from the core.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: byte address; bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `mem_rdata` out 32: read data, valid in the `mem_ready` cycle.
- `tests_passed` out 1: sticky pass flag.
- `tests_failed` out 1: sticky fail flag.
- `access_error` out 1: sticky flag for an out-of-range access.
- `proto_error` out 1: sticky flag for `mem_valid` dropped before `mem_ready`.
- `req_count` out 32: count of completed transactions; wraps.

## Operation

State machine: IDLE → WAIT → RESP → IDLE.

- **IDLE**
  - `mem_valid` = 1 captures addr/wdata/wstrb (the accept cycle).
  - The wait counter loads `LATENCY-1+extra`, where extra = `lfsr[1:0]` if `STALL_EN`, else 0.
  - Go to RESP if the counter value is 0, else go to WAIT.
- **WAIT**
  - Decrement the counter; go to RESP when it reaches 0.
  - `mem_valid` = 0 in any WAIT cycle means abort: set `proto_error`, go to IDLE, commit nothing.
- **RESP**
  - `mem_ready` = 1 for exactly one cycle.
  - Writes commit at the end of this cycle, byte-wise per `mem_wstrb`.
  - `req_count` increments; the state returns to IDLE.
  - `mem_valid` = 0 in RESP is also an abort: set `proto_error`, no `mem_ready`, no commit, no count.
- **Read data**
  - `mem_rdata` is registered on entry to RESP and holds its value until the next RESP.
- **Address decode** (word address = `mem_addr[31:2]`)
  - Word address equal to `PASS_ADDR>>2` selects MMIO.
    - Write with `mem_wstrb` = 4'hF and `mem_wdata` = `PASS_VALUE` sets `tests_passed`.
    - Any other write sets `tests_failed`.
    - Read returns {30'b0, `tests_failed`, `tests_passed`}.
  - Word address < `DEPTH_WORDS` selects `sram`.
  - Anything else is out of range: reads return 32'hDEAD_BEEF, writes are dropped, `access_error` is set. It still completes with `mem_ready`.
- **Stall LFSR**
  - 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5.
  - Advances once per accept.
  - Exists only when `STALL_EN` = 1.
- **Sticky flags**
  - Flags clear only on reset.
  - `tests_passed` and `tests_failed` may both be set.

## Timing

- **Reset values:** `mem_ready` 0, `mem_rdata` 0, all flags 0, `req_count` 0, state IDLE, LFSR 8'hA5.
- **Reset contents:** the `sram` contents are not affected by reset.
- **Latency:** accept in cycle k gives `mem_ready` in cycle k+`LATENCY`+extra.
  - Minimum, `LATENCY` = 1: ready in k+1.
- **Back-to-back:** a new request is not accepted in the RESP cycle. The earliest next accept is RESP+1, so throughput is one transaction per `LATENCY`+1 cycles.
- **Bus inputs:** addr/wdata/wstrb changing after accept are ignored.
- **Reset mid-transaction:** `resetn` low during WAIT or RESP aborts immediately and asynchronously.
  - `mem_ready` drops to 0.
  - A write not yet committed is lost.
  - `req_count` is not incremented.
- **Counter wrap:** `req_count` wraps from 32'hFFFF_FFFF to 0.

## Test plan

- **Read latency:** preload `sram[4]` = 32'h1234_5678, `LATENCY` = 3; read addr 0x10 → `mem_ready` exactly 3 cycles after accept, `mem_rdata` = 32'h1234_5678, `req_count` = 1.
- **Byte write:** write 0x10, `mem_wstrb` = 4'b0101, `mem_wdata` = 32'hAABB_CCDD over 32'h1234_5678; read back → 32'h12BB_56DD.
- **Pass/fail MMIO:** write `PASS_VALUE` to `PASS_ADDR` with strobe F → `tests_passed` = 1, `tests_failed` = 0; then write 0 → `tests_failed` = 1; read `PASS_ADDR` → 32'h3.
- **Out of range:** read at byte address 4×`DEPTH_WORDS` → `mem_rdata` = 32'hDEAD_BEEF, `access_error` = 1, `mem_ready` still pulses.
- **Protocol abort and reset:** drop `mem_valid` in WAIT during a write (`LATENCY` = 4) → `proto_error` = 1, memory unchanged, no `mem_ready`. Then assert `resetn` = 0 mid-WAIT → all outputs 0 asynchronously.
- **Random stalls:** `STALL_EN` = 1, 1000 random transactions against a scoreboard → every latency in `LATENCY`…`LATENCY`+3, data matches, `req_count` = 1000, no errors.

Source files
------------

// File: rtl/tb_mem_model.sv
// Simulation memory for the picorv32 native bus: configurable latency, optional
// pseudo-random stalls, pass/fail MMIO word, sticky error flags and a completion counter.
module tb_mem_model #(
  parameter int          DEPTH_WORDS = 32768,
  parameter int          LATENCY     = 1,
  parameter int          STALL_EN    = 0,
  parameter logic [31:0] PASS_ADDR   = 32'h1000_0000,
  parameter logic [31:0] PASS_VALUE  = 32'd123456789
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tests_passed,
  output logic        tests_failed,
  output logic        access_error,
  output logic        proto_error,
  output logic [31:0] req_count
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] MMIO_WA   = PASS_ADDR[31:2];
  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt, load_val;
  logic [29:0] addr_q, rd_wa;
  logic [31:0] wdata_q, rd_val;
  logic [3:0]  wstrb_q;
  logic [1:0]  extra;
  logic        accept, enter_resp, abort, commit, q_mmio, q_inr;
  logic [1:0]  unused_addr_lsb;

  logic [31:0] sram [DEPTH_WORDS];

  assign unused_addr_lsb = mem_addr[1:0];

  generate
    if (STALL_EN != 0) begin : g_lfsr
      logic [7:0] lfsr;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     lfsr <= 8'hA5;
        else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      assign extra = lfsr[1:0];
    end else begin : g_no_lfsr
      assign extra = 2'd0;
    end
  endgenerate

  assign accept    = (state == S_IDLE) && mem_valid;
  assign commit    = (state == S_RESP) && mem_valid;
  assign mem_ready = commit;
  assign load_val  = 32'(LATENCY - 1) + {30'b0, extra};
  assign q_mmio    = (addr_q == MMIO_WA);
  assign q_inr     = ({1'b0, addr_q} < DEPTH_LIM);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    abort        = 1'b0;
    case (state)
      S_IDLE: if (mem_valid) begin
        wait_cnt_nxt = load_val;
        if (load_val == 32'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: if (!mem_valid) begin
        abort     = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        wait_cnt_nxt = wait_cnt - 32'd1;
        if (wait_cnt == 32'd1) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        abort     = !mem_valid;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY=1 the response is loaded in the accept cycle, before addr_q is valid.
  always_comb begin
    rd_wa = (state == S_IDLE) ? mem_addr[31:2] : addr_q;
    if (rd_wa == MMIO_WA)                rd_val = {30'b0, tests_failed, tests_passed};
    else if ({1'b0, rd_wa} < DEPTH_LIM)  rd_val = sram[rd_wa[AW-1:0]];
    else                                 rd_val = 32'hDEAD_BEEF;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      mem_rdata    <= '0;
      tests_passed <= 1'b0;
      tests_failed <= 1'b0;
      access_error <= 1'b0;
      proto_error  <= 1'b0;
      req_count    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (enter_resp) mem_rdata <= rd_val;
      if (abort)      proto_error <= 1'b1;
      if (commit) begin
        req_count <= req_count + 32'd1;
        if (q_mmio) begin
          if (wstrb_q == 4'hF && wdata_q == PASS_VALUE) tests_passed <= 1'b1;
          else if (wstrb_q != 4'h0)                     tests_failed <= 1'b1;
        end else if (!q_inr) begin
          access_error <= 1'b1;
        end
      end
    end
  end

  // Contents survive reset so a preloaded image is kept across core resets.
  always_ff @(posedge clock) begin
    if (commit && q_inr && !q_mmio) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) sram[addr_q[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_tb_mem_model.sv
// Directed bench for tb_mem_model: instance 0 has fixed latency 3, instance 1 has
// latency 4 with random stalls whose exact length is predicted from the LFSR.
module tb_tb_mem_model;
  localparam int          DEPTH      = 1024;
  localparam logic [31:0] PASS_ADDR  = 32'h1000_0000;
  localparam logic [31:0] PASS_VALUE = 32'd123456789;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       rstn, valid;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       ready, passed, failed, aerr, perr;
  logic [1:0][31:0] rdata, cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  lfsr_m = 8'hA5;
  logic [31:0] model [16];

  tb_mem_model #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .STALL_EN(0),
                 .PASS_ADDR(PASS_ADDR), .PASS_VALUE(PASS_VALUE)) dut_a (
    .clock(clock), .resetn(rstn[0]), .mem_valid(valid[0]), .mem_ready(ready[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
    .tests_passed(passed[0]), .tests_failed(failed[0]), .access_error(aerr[0]),
    .proto_error(perr[0]), .req_count(cnt[0]));

  tb_mem_model #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .STALL_EN(1),
                 .PASS_ADDR(PASS_ADDR), .PASS_VALUE(PASS_VALUE)) dut_b (
    .clock(clock), .resetn(rstn[1]), .mem_valid(valid[1]), .mem_ready(ready[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
    .tests_passed(passed[1]), .tests_failed(failed[1]), .access_error(aerr[1]),
    .proto_error(perr[1]), .req_count(cnt[1]));

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // One bus transaction; bus fields are scrambled after accept to prove they are ignored.
  task automatic txn(input int s, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output int lat,
                     output int exp_lat);
    @(negedge clock);
    valid[s] = 1'b1; addr[s] = a; wdata[s] = wd; wstrb[s] = ws;
    if (s == 1) begin
      exp_lat = 4 + int'(lfsr_m[1:0]);
      lfsr_m  = lfsr_step(lfsr_m);
    end else begin
      exp_lat = 3;
    end
    rd  = '0;
    lat = 0;
    @(posedge clock);
    #1 addr[s] = 32'hFFFF_FFFC; wdata[s] = ~wd; wstrb[s] = ~ws;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      lat++;
      if (ready[s]) break;
    end
    if (!ready[s]) begin
      n_vec++; n_err++;
      $display("FAIL txn_timeout dut=%0d addr=%h: no mem_ready within 30 cycles", s, a);
      lat = -1;
    end else begin
      rd = rdata[s];
    end
    @(posedge clock);
    #1 valid[s] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if ({ready[s], passed[s], failed[s], aerr[s], perr[s]} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_flags dut=%0d got %b expected 00000", s,
                 {ready[s], passed[s], failed[s], aerr[s], perr[s]});
      end
      n_vec++;
      if (rdata[s] !== 32'h0 || cnt[s] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_data dut=%0d rdata=%h count=%h expected 0/0", s, rdata[s], cnt[s]);
      end
    end
    @(negedge clock);
    rstn = 2'b11;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd; int lat, el;
    txn(0, 32'h10, 32'h1234_5678, 4'hF, rd, lat, el);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL write_latency got %0d expected 3", lat); end
    txn(0, 32'h10, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL read_latency got %0d expected 3", lat); end
    n_vec++;
    if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL read_data got %h expected 12345678", rd); end
    n_vec++;
    if (cnt[0] !== 32'd2) begin n_err++; $display("FAIL read_count got %0d expected 2", cnt[0]); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; int lat, el;
    txn(0, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, lat, el);
    txn(0, 32'h10, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'h12BB_56DD) begin n_err++; $display("FAIL byte_write got %h expected 12bb56dd", rd); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; int lat, el;
    txn(0, PASS_ADDR, PASS_VALUE, 4'hF, rd, lat, el);
    n_vec++;
    if ({passed[0], failed[0]} !== 2'b10) begin
      n_err++; $display("FAIL mmio_pass got p/f=%b expected 10", {passed[0], failed[0]});
    end
    txn(0, PASS_ADDR, 32'h0, 4'hF, rd, lat, el);
    n_vec++;
    if ({passed[0], failed[0]} !== 2'b11) begin
      n_err++; $display("FAIL mmio_fail got p/f=%b expected 11", {passed[0], failed[0]});
    end
    txn(0, PASS_ADDR, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'h3) begin n_err++; $display("FAIL mmio_read got %h expected 00000003", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat, el;
    txn(0, 32'h0, 32'h1111_1111, 4'hF, rd, lat, el);
    n_vec++;
    if (aerr[0] !== 1'b0) begin n_err++; $display("FAIL oor_before got %b expected 0", aerr[0]); end
    txn(0, 32'(4 * DEPTH), 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF || lat !== 3) begin
      n_err++; $display("FAIL oor_read got %h lat %0d expected deadbeef lat 3", rd, lat);
    end
    n_vec++;
    if (aerr[0] !== 1'b1) begin n_err++; $display("FAIL oor_flag got %b expected 1", aerr[0]); end
    txn(0, 32'(4 * DEPTH), 32'h2222_2222, 4'hF, rd, lat, el);
    txn(0, 32'h0, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'h1111_1111) begin n_err++; $display("FAIL oor_write_dropped got %h expected 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [31:0] rd1;
    @(negedge clock);
    valid[0] = 1'b1; addr[0] = 32'h10; wstrb[0] = 4'h0;
    for (int i = 0; i < 30 && !ready[0]; i++) @(negedge clock);
    rd1 = rdata[0];
    @(posedge clock);
    #1 addr[0] = 32'h0;
    gap = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      gap++;
      if (ready[0]) break;
    end
    n_vec++;
    if (gap !== 4 || rd1 !== 32'h12BB_56DD || rdata[0] !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL back_to_back gap=%0d d1=%h d2=%h expected 4/12bb56dd/11111111",
               gap, rd1, rdata[0]);
    end
    @(posedge clock);
    #1 valid[0] = 1'b0;
    n_vec++;
    if (cnt[0] !== 32'd13) begin n_err++; $display("FAIL b2b_count got %0d expected 13", cnt[0]); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; int lat, el;
    logic seen;
    txn(1, 32'h20, 32'hCAFE_F00D, 4'hF, rd, lat, el);
    n_vec++;
    if (lat !== el) begin n_err++; $display("FAIL stall_first_lat got %0d expected %0d", lat, el); end
    @(negedge clock);
    valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0; wstrb[1] = 4'hF;
    lfsr_m = lfsr_step(lfsr_m);
    seen = 1'b0;
    @(negedge clock); seen |= ready[1];
    @(negedge clock); seen |= ready[1];
    valid[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clock); seen |= ready[1]; end
    n_vec++;
    if (perr[1] !== 1'b1 || seen !== 1'b0) begin
      n_err++; $display("FAIL abort got proto=%b ready_seen=%b expected 1/0", perr[1], seen);
    end
    txn(1, 32'h20, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'hCAFE_F00D || lat !== el || cnt[1] !== 32'd2) begin
      n_err++; $display("FAIL abort_unchanged got %h lat %0d cnt %0d expected cafef00d %0d 2",
                        rd, lat, cnt[1], el);
    end
    @(negedge clock);
    valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0; wstrb[1] = 4'hF;
    @(negedge clock);
    valid[1] = 1'b0;
    rstn[1]  = 1'b0;
    #1;
    n_vec++;
    if ({ready[1], perr[1], aerr[1], passed[1], failed[1]} !== 5'b0 ||
        rdata[1] !== 32'h0 || cnt[1] !== 32'h0) begin
      n_err++; $display("FAIL async_reset got flags=%b rdata=%h cnt=%h expected all 0",
                        {ready[1], perr[1], aerr[1], passed[1], failed[1]}, rdata[1], cnt[1]);
    end
    @(negedge clock);
    rstn[1] = 1'b1;
    lfsr_m  = 8'hA5;
    txn(1, 32'h20, 32'h0, 4'h0, rd, lat, el);
    n_vec++;
    if (rd !== 32'hCAFE_F00D || lat !== 5) begin
      n_err++; $display("FAIL reset_write_lost got %h lat %0d expected cafef00d lat 5", rd, lat);
    end
  endtask

  task automatic test_random_stalls();
    logic [31:0] rd, wd; int lat, el, a; logic [3:0] ws;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      txn(1, 32'(4 * i), model[i], 4'hF, rd, lat, el);
    end
    @(negedge clock); rstn[1] = 1'b0;
    @(negedge clock); rstn[1] = 1'b1;
    lfsr_m = 8'hA5;
    for (int n = 0; n < 1000; n++) begin
      a  = int'($urandom_range(0, 15));
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      txn(1, 32'(4 * a), wd, ws, rd, lat, el);
      n_vec++;
      if (lat !== el) begin n_err++; $display("FAIL rand_lat n=%0d got %0d expected %0d", n, lat, el); end
      if (ws == 4'h0) begin
        n_vec++;
        if (rd !== model[a]) begin
          n_err++; $display("FAIL rand_data n=%0d addr=%0d got %h expected %h", n, a, rd, model[a]);
        end
      end else begin
        for (int b = 0; b < 4; b++) if (ws[b]) model[a][8*b +: 8] = wd[8*b +: 8];
      end
    end
    n_vec++;
    if (cnt[1] !== 32'd1000) begin n_err++; $display("FAIL rand_count got %0d expected 1000", cnt[1]); end
    n_vec++;
    if ({aerr[1], perr[1], passed[1], failed[1]} !== 4'b0) begin
      n_err++; $display("FAIL rand_flags got %b expected 0000", {aerr[1], perr[1], passed[1], failed[1]});
    end
  endtask

  initial begin
    rstn  = 2'b00;
    valid = 2'b00;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    test_reset();
    test_read_latency();
    test_byte_write();
    test_mmio();
    test_out_of_range();
    test_back_to_back();
    test_abort_reset();
    test_random_stalls();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
